// File: rtl/ex_mem_stage.sv
// Elastic EX->MEM pipeline register: valid/ready handshake, 2-entry skid buffer,
// flush, gating of side-effect controls on bubbles, saturating stall counter.
module ex_mem_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter bit NEGEDGE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  RegWriteE,
  input  logic                  ResultSrcE,
  input  logic                  MemWriteE,
  input  logic [XLEN-1:0]       ALUResultE,
  input  logic [XLEN-1:0]       WriteDataE,
  input  logic [REG_ADDR_W-1:0] RdE,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  RegWriteM,
  output logic                  ResultSrcM,
  output logic                  MemWriteM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  reg_write;
    logic                  result_src;
    logic                  mem_write;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       wdata;
    logic [REG_ADDR_W-1:0] rd;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

  state_t           state_q, state_d;
  beat_t            main_q, main_d, skid_q, skid_d, in_beat;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             main_valid, skid_valid, acc, con;

  assign in_beat    = '{reg_write: RegWriteE, result_src: ResultSrcE, mem_write: MemWriteE,
                        alu: ALUResultE, wdata: WriteDataE, rd: RdE};
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL2);
  assign in_ready   = !skid_valid;
  assign out_valid  = main_valid;
  assign acc        = in_valid & in_ready;
  assign con        = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = FULL1;
        main_d  = in_beat;
      end
      FULL1: begin
        if (acc && con) begin
          main_d = in_beat;
        end else if (acc) begin
          state_d = FULL2;
          skid_d  = in_beat;
        end else if (con) begin
          state_d = EMPTY;
        end
      end
      FULL2: if (con) begin
        state_d = FULL1;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops occupancy; payload fields keep their last values.
    if (flush) state_d = EMPTY;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  generate
    if (NEGEDGE) begin : g_neg
      always_ff @(negedge clk) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          stall_q <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          stall_q <= stall_d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          stall_q <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          stall_q <= stall_d;
        end
      end
    end
  endgenerate

  // Side-effect controls must never fire on a bubble.
  assign RegWriteM  = main_q.reg_write & main_valid;
  assign MemWriteM  = main_q.mem_write & main_valid;
  assign ResultSrcM = main_q.result_src;
  assign ALUResultM = main_q.alu;
  assign WriteDataM = main_q.wdata;
  assign RdM        = main_q.rd;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; a second instance with a 4-bit stall counter
// exercises saturation. State moves on the falling edge, outputs are sampled at posedge.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        RegWriteE, ResultSrcE, MemWriteE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [4:0]  RdE;

  logic        in_ready, out_valid, RegWriteM, ResultSrcM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_RegWriteM, s_ResultSrcM, s_MemWriteM;
  logic [31:0] s_ALUResultM, s_WriteDataM;
  logic [4:0]  s_RdM;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_mem_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .RegWriteM(s_RegWriteM), .ResultSrcM(s_ResultSrcM), .MemWriteM(s_MemWriteM),
    .ALUResultM(s_ALUResultM), .WriteDataM(s_WriteDataM), .RdM(s_RdM),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Let one active (falling) edge pass, then return at the following rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic offer(input logic v, input logic [31:0] alu, input logic mw);
    in_valid   = v;
    ALUResultE = alu;
    MemWriteE  = mw;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    RegWriteE = 1'b1; ResultSrcE = 1'b1; MemWriteE = 1'b1;
    ALUResultE = 32'h55; WriteDataE = 32'h66; RdE = 5'd3; in_valid = 1'b1;
    @(posedge clk);

    // 1: reset dominates an offered beat
    tick(); tick();
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst occupancy", occupancy, 0);
    check_eq("rst in_ready", in_ready, 1);
    check_eq("rst RegWriteM", RegWriteM, 0);
    check_eq("rst MemWriteM", MemWriteM, 0);
    check_eq("rst ResultSrcM", ResultSrcM, 0);
    check_eq("rst ALUResultM", ALUResultM, 0);
    check_eq("rst WriteDataM", WriteDataM, 0);
    check_eq("rst RdM", RdM, 0);
    check_eq("rst stall_cnt", stall_cnt, 0);

    // 2: streaming with the M side always ready
    rst_n = 1'b1; out_ready = 1'b1; RegWriteE = 1'b0; MemWriteE = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      offer(1'b1, 32'(i * 16), 1'b0);
      tick();
      check_eq("stream ALUResultM", ALUResultM, 64'(i * 16));
      check_eq("stream out_valid", out_valid, 1);
      check_eq("stream occupancy", occupancy, 1);
      check_eq("stream in_ready", in_ready, 1);
    end
    offer(1'b0, 32'h0, 1'b0);
    tick();
    check_eq("drain out_valid", out_valid, 0);
    check_eq("drain occupancy", occupancy, 0);

    // 3: backpressure fills the skid entry, then FIFO drain
    out_ready = 1'b0;
    offer(1'b1, 32'hA, 1'b0); tick();
    check_eq("bp A occupancy", occupancy, 1);
    check_eq("bp A in_ready", in_ready, 1);
    offer(1'b1, 32'hB, 1'b0); tick();
    check_eq("bp B occupancy", occupancy, 2);
    check_eq("bp B in_ready", in_ready, 0);
    check_eq("bp B ALUResultM", ALUResultM, 32'hA);
    offer(1'b1, 32'hC, 1'b0); tick();
    check_eq("bp C held in_ready", in_ready, 0);
    check_eq("bp C held ALUResultM", ALUResultM, 32'hA);
    check_eq("bp stall_cnt", stall_cnt, 2);
    out_ready = 1'b1; tick();
    check_eq("bp out B", ALUResultM, 32'hB);
    check_eq("bp out B occupancy", occupancy, 1);
    check_eq("bp out B in_ready", in_ready, 1);
    tick();
    check_eq("bp out C", ALUResultM, 32'hC);
    check_eq("bp out C occupancy", occupancy, 1);
    offer(1'b0, 32'h0, 1'b0); tick();
    check_eq("bp empty", occupancy, 0);
    check_eq("bp stall_cnt final", stall_cnt, 2);

    // 4: flush with both entries held and a beat on offer
    out_ready = 1'b0;
    offer(1'b1, 32'h1, 1'b1); tick();
    offer(1'b1, 32'h2, 1'b1); tick();
    check_eq("fl pre occupancy", occupancy, 2);
    check_eq("fl pre MemWriteM", MemWriteM, 1);
    offer(1'b1, 32'h3, 1'b1); flush = 1'b1;
    check_eq("fl in_ready registered", in_ready, 0);
    tick();
    check_eq("fl occupancy", occupancy, 0);
    check_eq("fl out_valid", out_valid, 0);
    check_eq("fl MemWriteM", MemWriteM, 0);
    check_eq("fl stall_cnt kept", stall_cnt, 4);
    flush = 1'b0; offer(1'b0, 32'h0, 1'b0); out_ready = 1'b1; tick();
    check_eq("fl no ghost out_valid", out_valid, 0);

    // 5: bubble gating after a store beat is consumed
    RegWriteE = 1'b1; ResultSrcE = 1'b1; WriteDataE = 32'h1234; RdE = 5'd7;
    offer(1'b1, 32'h77, 1'b1); tick();
    check_eq("bub beat MemWriteM", MemWriteM, 1);
    check_eq("bub beat RegWriteM", RegWriteM, 1);
    offer(1'b0, 32'h0, 1'b0); tick();
    check_eq("bub MemWriteM", MemWriteM, 0);
    check_eq("bub RegWriteM", RegWriteM, 0);
    check_eq("bub ALUResultM", ALUResultM, 32'h77);
    check_eq("bub WriteDataM", WriteDataM, 32'h1234);
    check_eq("bub RdM", RdM, 7);
    check_eq("bub ResultSrcM", ResultSrcM, 1);

    // 6: stall counter saturation on the 4-bit instance
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("sat after reset", s_stall_cnt, 0);
    out_ready = 1'b0;
    offer(1'b1, 32'h99, 1'b0); tick();
    offer(1'b0, 32'h0, 1'b0);
    repeat (10) tick();
    check_eq("sat mid stall_cnt", s_stall_cnt, 10);
    repeat (10) tick();
    check_eq("sat stall_cnt", s_stall_cnt, 15);
    check_eq("wide stall_cnt", stall_cnt, 20);
    check_eq("sat out_valid", s_out_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
